// File: rtl/imem_loader.sv
// Boot loader: assembles a LEN/DATA/CHK byte stream into 32-bit words for instruction memory.
// Latency: each word is written one cycle after its 4th byte is accepted; done/error follow CHK by one cycle.
// Backpressure: s_ready is high in every loading state, and byte acceptance never stalls for a write.
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHECK, S_DONE, S_ERR
    } state_t;

    // Largest legal word count; N equal to this is still accepted.
    localparam logic [16:0]           CAPACITY = 17'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   ONE      = 1;

    state_t                state;
    logic [7:0]            xor_acc;
    logic [7:0]            len_lo;
    logic [ADDR_WIDTH:0]   n_words;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [1:0]            byte_cnt;
    logic [23:0]           word_buf;

    logic                  accept;
    logic [16:0]           len17;
    logic [ADDR_WIDTH:0]   word_next;

    // busy is a registered decode of LEN0..CHECK, which is exactly when bytes are taken.
    assign s_ready   = busy;
    assign accept    = s_valid && s_ready;
    assign len17     = {1'b0, s_data, len_lo};
    assign word_next = word_cnt + ONE;

    // Loader FSM; all outputs are registered alongside the state transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            xor_acc      <= 8'h00;
            len_lo       <= 8'h00;
            n_words      <= '0;
            word_cnt     <= '0;
            byte_cnt     <= 2'd0;
            word_buf     <= 24'h0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'h0;
            core_reset_n <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_LEN0;
                        xor_acc      <= 8'h00;
                        word_cnt     <= '0;
                        byte_cnt     <= 2'd0;
                        words_loaded <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        core_reset_n <= 1'b0;
                    end
                end
                S_LEN0: begin
                    if (accept) begin
                        len_lo  <= s_data;
                        xor_acc <= xor_acc ^ s_data;
                        state   <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (accept) begin
                        xor_acc <= xor_acc ^ s_data;
                        n_words <= len17[ADDR_WIDTH:0];
                        if (len17 == 17'd0) begin
                            state <= S_CHECK;
                        end else if (len17 > CAPACITY) begin
                            state <= S_ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        xor_acc  <= xor_acc ^ s_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= s_data;
                            2'd1: word_buf[15:8]  <= s_data;
                            2'd2: word_buf[23:16] <= s_data;
                            default: begin
                                // Word complete: issue the write and count it in the same cycle.
                                imem_we      <= 1'b1;
                                imem_addr    <= word_cnt[ADDR_WIDTH-1:0];
                                imem_wdata   <= {s_data, word_buf};
                                word_cnt     <= word_next;
                                words_loaded <= word_next;
                                if (word_next == n_words) begin
                                    state <= S_CHECK;
                                end
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (s_data == xor_acc) begin
                            state        <= S_DONE;
                            done         <= 1'b1;
                            core_reset_n <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, empty image, size limit, gaps, mid-load reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// Every wait on s_ready is bounded by a cycle budget.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready, imem_we, core_reset_n, busy, done, error;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] words_loaded;

    logic        start4 = 1'b0;
    logic        s_valid4 = 1'b0;
    logic [7:0]  s_data4 = 8'h00;
    logic        s_ready4, we4, crn4, busy4, done4, error4;
    logic [3:0]  addr4;
    logic [31:0] wdata4;
    logic [4:0]  wl4;

    int n_checks = 0;
    int n_fail   = 0;
    int we4_n    = 0;
    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  stream[10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset_n(core_reset_n), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    imem_loader #(.ADDR_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .s_valid(s_valid4), .s_data(s_data4),
        .s_ready(s_ready4), .imem_we(we4), .imem_addr(addr4), .imem_wdata(wdata4),
        .core_reset_n(crn4), .busy(busy4), .done(done4), .error(error4),
        .words_loaded(wl4)
    );

    // Write monitors: log every memory write pulse.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
        if (we4) we4_n++;
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        s_data  = b;
        s_valid = 1'b1;
        t = 0;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: s_ready=%b want 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] b);
        int t;
        s_data4  = b;
        s_valid4 = 1'b1;
        t = 0;
        while (!s_ready4 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL send4_timeout: s_ready=%b want 1", s_ready4);
        end
        @(negedge clk);
        s_valid4 = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", imem_we); end
        n_checks++; if (core_reset_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            n_fail++; $display("FAIL rst_status: got crn=%b busy=%b done=%b err=%b want all 0", core_reset_n, busy, done, error);
        end
        n_checks++; if (imem_addr !== 10'd0 || imem_wdata !== 32'd0 || words_loaded !== 11'd0) begin
            n_fail++; $display("FAIL rst_data: got addr=%h wdata=%h wl=%0d want 0", imem_addr, imem_wdata, words_loaded);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_load_ok();
        int base;
        base = wr_addr.size();
        pulse_start();
        n_checks++; if (s_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL ok_ready: got %b want 1", s_ready); end
        for (int i = 0; i < 10; i++) begin
            send_byte(stream[i]);
            if (i == 5) begin
                n_checks++; if (imem_we !== 1'b1 || imem_addr !== 10'd0 || imem_wdata !== 32'h00500093) begin
                    n_fail++; $display("FAIL ok_w0: got we=%b addr=%h data=%h want 1 000 00500093", imem_we, imem_addr, imem_wdata);
                end
                n_checks++; if (words_loaded !== 11'd1) begin n_fail++; $display("FAIL ok_wl1: got %0d want 1", words_loaded); end
            end
        end
        n_checks++; if (imem_we !== 1'b1 || imem_addr !== 10'd1 || imem_wdata !== 32'h00A00113 || busy !== 1'b1) begin
            n_fail++; $display("FAIL ok_w1: got we=%b addr=%h data=%h busy=%b want 1 001 00a00113 1", imem_we, imem_addr, imem_wdata, busy);
        end
        send_byte(8'h73);
        n_checks++; if (done !== 1'b1 || core_reset_n !== 1'b1 || error !== 1'b0) begin
            n_fail++; $display("FAIL ok_done: got done=%b crn=%b err=%b want 1 1 0", done, core_reset_n, error);
        end
        n_checks++; if (words_loaded !== 11'd2 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL ok_wl: got wl=%0d rdy=%b want 2 0", words_loaded, s_ready);
        end
        n_checks++; if (wr_addr.size() !== base + 2) begin n_fail++; $display("FAIL ok_nwr: got %0d want %0d", wr_addr.size(), base + 2); end
    endtask

    task automatic test_bad_chk();
        int base;
        base = wr_addr.size();
        pulse_start();
        n_checks++; if (core_reset_n !== 1'b0 || done !== 1'b0 || words_loaded !== 11'd0) begin
            n_fail++; $display("FAIL bad_reload: got crn=%b done=%b wl=%0d want 0 0 0", core_reset_n, done, words_loaded);
        end
        for (int i = 0; i < 10; i++) send_byte(stream[i]);
        send_byte(8'h74);
        n_checks++; if (error !== 1'b1 || done !== 1'b0 || core_reset_n !== 1'b0) begin
            n_fail++; $display("FAIL bad_status: got err=%b done=%b crn=%b want 1 0 0", error, done, core_reset_n);
        end
        n_checks++; if (wr_addr.size() !== base + 2) begin n_fail++; $display("FAIL bad_nwr: got %0d want %0d", wr_addr.size(), base + 2); end
        n_checks++; if (words_loaded !== 11'd2) begin n_fail++; $display("FAIL bad_wl: got %0d want 2", words_loaded); end
    endtask

    task automatic test_zero_len();
        int base;
        base = wr_addr.size();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        n_checks++; if (done !== 1'b1 || error !== 1'b0 || core_reset_n !== 1'b1) begin
            n_fail++; $display("FAIL zero_done: got done=%b err=%b crn=%b want 1 0 1", done, error, core_reset_n);
        end
        n_checks++; if (words_loaded !== 11'd0) begin n_fail++; $display("FAIL zero_wl: got %0d want 0", words_loaded); end
        n_checks++; if (wr_addr.size() !== base) begin n_fail++; $display("FAIL zero_nwr: got %0d want %0d", wr_addr.size(), base); end
    endtask

    task automatic test_len_limit();
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        send4(8'h11);
        send4(8'h00);
        n_checks++; if (error4 !== 1'b1 || s_ready4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            n_fail++; $display("FAIL lim_err: got err=%b rdy=%b busy=%b done=%b want 1 0 0 0", error4, s_ready4, busy4, done4);
        end
        n_checks++; if (we4_n !== 0 || crn4 !== 1'b0) begin n_fail++; $display("FAIL lim_nwr: got %0d want 0", we4_n); end
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        send4(8'h10);
        send4(8'h00);
        n_checks++; if (error4 !== 1'b0 || s_ready4 !== 1'b1 || busy4 !== 1'b1) begin
            n_fail++; $display("FAIL lim_max: got err=%b rdy=%b busy=%b want 0 1 1", error4, s_ready4, busy4);
        end
    endtask

    task automatic test_gaps();
        int base;
        base = wr_addr.size();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (i == 7) pulse_start();
            send_byte(stream[i]);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_byte(8'h73);
        n_checks++; if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 11'd2) begin
            n_fail++; $display("FAIL gap_done: got done=%b err=%b wl=%0d want 1 0 2", done, error, words_loaded);
        end
        n_checks++; if (wr_addr.size() !== base + 2) begin
            n_fail++; $display("FAIL gap_nwr: got %0d want %0d", wr_addr.size(), base + 2);
        end else begin
            n_checks++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'h00500093) begin
                n_fail++; $display("FAIL gap_w0: got %h %h want 000 00500093", wr_addr[base], wr_data[base]);
            end
            n_checks++; if (wr_addr[base+1] !== 10'd1 || wr_data[base+1] !== 32'h00A00113) begin
                n_fail++; $display("FAIL gap_w1: got %h %h want 001 00a00113", wr_addr[base+1], wr_data[base+1]);
            end
        end
    endtask

    task automatic test_reset_midload();
        int base;
        base = wr_addr.size();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(stream[i]);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_we !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || words_loaded !== 11'd0) begin
            n_fail++; $display("FAIL mid_rst: got we=%b busy=%b rdy=%b wl=%0d want 0 0 0 0", imem_we, busy, s_ready, words_loaded);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (wr_addr.size() !== base + 1) begin
            n_fail++; $display("FAIL mid_nwr: got %0d want %0d", wr_addr.size(), base + 1);
        end
        base = wr_addr.size();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(stream[i]);
        send_byte(8'h73);
        n_checks++; if (done !== 1'b1 || core_reset_n !== 1'b1 || words_loaded !== 11'd2) begin
            n_fail++; $display("FAIL mid_done: got done=%b crn=%b wl=%0d want 1 1 2", done, core_reset_n, words_loaded);
        end
        n_checks++; if (wr_addr.size() !== base + 2) begin
            n_fail++; $display("FAIL mid_reload_nwr: got %0d want %0d", wr_addr.size(), base + 2);
        end else begin
            n_checks++; if (wr_data[base] !== 32'h00500093 || wr_data[base+1] !== 32'h00A00113 || wr_addr[base+1] !== 10'd1) begin
                n_fail++; $display("FAIL mid_data: got %h %h want 00500093 00a00113", wr_data[base], wr_data[base+1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_ok();
        test_bad_chk();
        test_zero_len();
        test_len_limit();
        test_gaps();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
